// File: rtl/reg_bank_wb.sv
// Write-back register bank: NREGS x bits registers, two zero-latency read ports
// with write-first bypass, registered Z/N flags and a committed-write counter.
module reg_bank_wb #(
  parameter int bits    = 8,
  parameter int NREGS   = 4,
  parameter bit LOCK_R0 = 1'b0,
  localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [bits-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [bits-1:0] rdata_a,
  output logic [bits-1:0] rdata_b,
  output logic            flag_z,
  output logic            flag_n,
  output logic [7:0]      wr_cnt
);

  logic [bits-1:0] regs [NREGS];
  logic            wr_ok;
  logic            commit;

  // A write is dropped when it targets a register that does not exist or the
  // hard-wired zero register.
  assign wr_ok  = (int'(waddr) < NREGS) && !(LOCK_R0 && (waddr == '0));
  assign commit = we && wr_ok;

  // Reset deliberately precedes the commit: a write in a reset cycle is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this bank is small and architecturally visible, so every entry is
      // cleared on reset; large storage arrays are normally left unreset.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flag_z <= 1'b1;
      flag_n <= 1'b0;
      wr_cnt <= '0;
    end else if (commit) begin
      // NOTE: state uses non-blocking assignment so every register samples the
      // pre-edge values regardless of statement order.
      regs[waddr] <= wdata;
      flag_z      <= (wdata == '0);
      flag_n      <= wdata[bits-1];
      wr_cnt      <= wr_cnt + 8'd1;
    end
  end

  // All inputs passed explicitly so the read path is sensitive to every one.
  function automatic logic [bits-1:0] rd_port(
    input logic [AW-1:0]   idx,
    input logic            byp,
    input logic [AW-1:0]   w_idx,
    input logic [bits-1:0] w_data,
    input logic [bits-1:0] mem [NREGS]
  );
    if (int'(idx) >= NREGS)             return '0;
    if (LOCK_R0 && (idx == '0))         return '0;
    if (byp && (idx == w_idx))          return w_data;
    return mem[idx];
  endfunction

  // Bypass ignores rst on purpose: the ALU sees the write-back value this cycle.
  assign rdata_a = rd_port(raddr_a, commit, waddr, wdata, regs);
  assign rdata_b = rd_port(raddr_b, commit, waddr, wdata, regs);

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed self-checking bench for reg_bank_wb: a default instance (4 regs)
// and a locked-R0 instance with 3 registers.
module tb_reg_bank_wb;

  logic       clk = 1'b0;
  logic       rst;

  logic       we, we_l;
  logic [1:0] waddr, raddr_a, raddr_b;
  logic [1:0] waddr_l, raddr_a_l, raddr_b_l;
  logic [7:0] wdata, wdata_l;
  logic [7:0] rdata_a, rdata_b, rdata_a_l, rdata_b_l;
  logic       flag_z, flag_n, flag_z_l, flag_n_l;
  logic [7:0] wr_cnt, wr_cnt_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_wb dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .flag_z(flag_z), .flag_n(flag_n), .wr_cnt(wr_cnt)
  );

  reg_bank_wb #(.bits(8), .NREGS(3), .LOCK_R0(1'b1)) dut_l (
    .clk(clk), .rst(rst), .we(we_l), .waddr(waddr_l), .wdata(wdata_l),
    .raddr_a(raddr_a_l), .raddr_b(raddr_b_l), .rdata_a(rdata_a_l), .rdata_b(rdata_b_l),
    .flag_z(flag_z_l), .flag_n(flag_n_l), .wr_cnt(wr_cnt_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance through one rising edge; inputs change and checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    we_l = 1'b0; waddr_l = '0; wdata_l = '0; raddr_a_l = '0; raddr_b_l = '0;
    tick();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) begin
      raddr_a = 2'(i); raddr_b = 2'(i); #1;
      check($sformatf("rst_a_r%0d", i), rdata_a, 8'h00);
      check($sformatf("rst_b_r%0d", i), rdata_b, 8'h00);
    end
    check("rst_z", flag_z, 1'b1);
    check("rst_n", flag_n, 1'b0);
    check("rst_cnt", wr_cnt, 8'd0);
    check("rst_l_z", flag_z_l, 1'b1);
    check("rst_l_cnt", wr_cnt_l, 8'd0);

    // Write/read
    we = 1'b1; waddr = 2'd2; wdata = 8'hA5; raddr_a = 2'd0;
    tick();
    we = 1'b0; raddr_a = 2'd2; #1;
    check("wr_r2", rdata_a, 8'hA5);
    check("wr_n", flag_n, 1'b1);
    check("wr_z", flag_z, 1'b0);
    check("wr_cnt", wr_cnt, 8'd1);

    // Bypass, both ports on the same register
    we = 1'b1; waddr = 2'd1; wdata = 8'h3C; raddr_a = 2'd1; raddr_b = 2'd1; #1;
    check("byp_a", rdata_a, 8'h3C);
    check("byp_b", rdata_b, 8'h3C);
    check("byp_cnt_pre", wr_cnt, 8'd1);
    tick();
    we = 1'b0; #1;
    check("byp_r1_after", rdata_a, 8'h3C);
    check("byp_cnt", wr_cnt, 8'd2);

    // Flags
    we = 1'b1; waddr = 2'd3; wdata = 8'h00;
    tick();
    check("flag0_z", flag_z, 1'b1);
    check("flag0_n", flag_n, 1'b0);
    wdata = 8'h80;
    tick();
    we = 1'b0; raddr_b = 2'd3; #1;
    check("flag80_z", flag_z, 1'b0);
    check("flag80_n", flag_n, 1'b1);
    check("flag80_r3", rdata_b, 8'h80);
    check("flag80_cnt", wr_cnt, 8'd4);

    // we=0 holds all state and does not bypass
    we = 1'b0; waddr = 2'd0; wdata = 8'hFF; raddr_a = 2'd0; #1;
    check("hold_nobyp", rdata_a, 8'h00);
    tick();
    check("hold_r0", rdata_a, 8'h00);
    check("hold_cnt", wr_cnt, 8'd4);
    check("hold_n", flag_n, 1'b1);

    // Locked R0 / NREGS=3 instance
    we_l = 1'b1; waddr_l = 2'd1; wdata_l = 8'h7F;
    tick();
    check("l_cnt1", wr_cnt_l, 8'd1);
    check("l_z1", flag_z_l, 1'b0);
    check("l_n1", flag_n_l, 1'b0);
    waddr_l = 2'd0; wdata_l = 8'hFF; raddr_a_l = 2'd0; raddr_b_l = 2'd1; #1;
    check("l_r0_nobyp", rdata_a_l, 8'h00);
    tick();
    check("l_r0_read", rdata_a_l, 8'h00);
    check("l_r1_read", rdata_b_l, 8'h7F);
    check("l_r0_cnt", wr_cnt_l, 8'd1);
    check("l_r0_n", flag_n_l, 1'b0);
    check("l_r0_z", flag_z_l, 1'b0);
    waddr_l = 2'd3; wdata_l = 8'hAA; raddr_b_l = 2'd3; #1;
    check("l_oob_nobyp", rdata_b_l, 8'h00);
    tick();
    we_l = 1'b0; #1;
    check("l_oob_read", rdata_b_l, 8'h00);
    check("l_oob_cnt", wr_cnt_l, 8'd1);
    check("l_oob_n", flag_n_l, 1'b0);

    // Reset beats a write; bypass still visible during the reset cycle
    rst = 1'b1; we = 1'b1; waddr = 2'd0; wdata = 8'h55; raddr_a = 2'd0; raddr_b = 2'd2; #1;
    check("rstw_byp", rdata_a, 8'h55);
    tick();
    rst = 1'b0; we = 1'b0; #1;
    check("rstw_r0", rdata_a, 8'h00);
    check("rstw_r2", rdata_b, 8'h00);
    check("rstw_cnt", wr_cnt, 8'd0);
    check("rstw_z", flag_z, 1'b1);

    // Counter wrap
    we = 1'b1; waddr = 2'd1; raddr_a = 2'd1;
    for (int i = 0; i < 255; i++) begin
      wdata = 8'(i);
      tick();
    end
    check("wrap_255", wr_cnt, 8'd255);
    wdata = 8'hFF;
    tick();
    we = 1'b0; #1;
    check("wrap_0", wr_cnt, 8'd0);
    check("wrap_r1", rdata_a, 8'hFF);
    check("wrap_n", flag_n, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
